ones_mask_gen: RTL and testbench
================================

Name: ones_mask_gen

Overview:
- Inverse of the team's ones-counter: takes a count k and builds, bit-serially, a WIDTH-bit word with exactly k ones packed at the LSB end (thermometer code).
- Built as a multi-cycle shift datapath driven by a Moore control FSM.
- Uses the same init/done start-and-finish handshake as the counter, so the two can be chained in loopback tests.

Parameters:
- WIDTH, default 8: width of the generated word. Must be ≥ 2.
- CW, default $clog2(WIDTH+1) (4 when WIDTH=8): width of the count input. Derived from WIDTH; never overridden independently.

Ports:
- clk  input  1  clock. All registers update on the falling edge.
- rst  input  1  reset. Synchronous, active-high, sampled on the falling edge of clk.
- init  input  1  start request. Sampled only in state START.
- count  input  CW  requested number of ones. Sampled in state LOAD.
- result  output  WIDTH  generated word (registered).
- busy  output  1  high in every state except START.
- done  output  1  high for exactly one cycle, in state DONE.

Behaviour:
- Reset values: state=START, result=0, internal down-counter cnt=0, busy=0, done=0.
- rst has priority over everything, including mid-operation. A reset during any state returns to START on that edge and clears result to 0.
- States (3-bit encoding): START=000, LOAD=001, CHECK=010, SHIFT=011, DONE=100. Unused codes go to START on the next edge.
- Transitions:
  - START: init=1 -> LOAD; otherwise stay in START.
  - LOAD -> CHECK. On the same edge: result<=0 and cnt<=min(count, WIDTH).
  - CHECK: cnt==0 -> DONE; otherwise -> SHIFT.
  - SHIFT -> CHECK. On the same edge: result<={result[WIDTH-2:0],1'b1} and cnt<=cnt-1.
  - DONE -> START, unconditionally.
- Outputs:
  - busy and done are decoded combinationally from state only (Moore).
  - result holds its value from DONE until the next LOAD edge.
- Latency: edges from the edge that samples init=1 to entering DONE = 3+2k, where k is the saturated count. k=0 gives 3; k=WIDTH=8 gives 19.
- Saturation: a count greater than WIDTH is clamped to WIDTH, giving result = all ones. cnt never underflows.
- init held high continuously: a new operation starts on the edge after DONE returns to START. There is no lost or duplicated cycle.
- init while busy: ignored.
- count is ignored in every state except LOAD, so changes to it mid-operation have no effect.
- Invariant: in every CHECK state, popcount(result) + cnt equals the saturated count.

Decomposition:
- Shared package ones_gen_pkg holds:
  - the state encoding constants (START, LOAD, CHECK, SHIFT, DONE);
  - a helper function that computes CW from WIDTH.
- One natural sub-module: control_ones_gen.
  - Inputs: clk, rst, init, and z = (cnt==0).
  - Outputs: ld, sft, busy, done.
  - It mirrors the counter controller's structure. The top level keeps the result shift register, the cnt register and the saturation compare.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> result=0, busy=0, done=0, and the FSM stays in START while init=0.
- count=3, pulse init (WIDTH=8) -> done pulses for exactly 1 cycle, 9 edges after the init-sampling edge; result=8'b0000_0111; busy falls with done.
- count=0 -> done 3 edges after init; result=8'h00. count=8 -> done after 19 edges; result=8'hFF.
- count=13 (above WIDTH) -> saturates: result=8'hFF, done after 19 edges. Also change count mid-operation -> result is unaffected.
- Reset mid-operation: count=6, assert rst on the 5th edge after init -> next state START, result=0, no done pulse. Then rerun with count=2 -> result=8'h03.
- Loopback: feed result into the existing ones-counter and sweep count 0..15 -> the counter reports min(count, 8) every time. With init held high, runs go back-to-back with one START cycle between them.

Source files
------------

// File: rtl/ones_mask_gen_pkg.sv
// Shared definitions for the ones-mask generator: control state encoding
// and the count-width helper.
package ones_gen_pkg;

  typedef enum logic [2:0] {
    START = 3'b000,
    LOAD  = 3'b001,
    CHECK = 3'b010,
    SHIFT = 3'b011,
    DONE  = 3'b100
  } state_t;

  // Bits needed to hold any count from 0 to width inclusive.
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ones_mask_gen_if.sv
// Start/finish bus of the ones-mask generator, with the control state
// exposed for observation.
interface ones_mask_gen_if
  import ones_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = calc_cw(WIDTH)
) ();

  // init is a start request that is honoured only while busy is low.
  // busy stays high from the accepting edge until the operation returns
  // to idle. done pulses for one cycle with result already valid, and
  // result then holds until the next operation loads.
  logic             init;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  state_t           state;

  modport master (
    output init, count,
    input  result, busy, done, state
  );

  modport slave (
    input  init, count,
    output result, busy, done, state
  );

endinterface

// File: rtl/ones_mask_gen_control.sv
// Moore controller for the ones-mask generator. Sequences the load and the
// shift steps, and decodes busy/done from the state alone.
module control_ones_gen
  import ones_gen_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   init,
  input  logic   z,
  output logic   ld,
  output logic   sft,
  output logic   busy,
  output logic   done,
  output state_t state
);

  state_t state_q;
  state_t state_d;

  always_ff @(negedge clk) begin
    if (rst) state_q <= START;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = START;
    ld      = 1'b0;
    sft     = 1'b0;
    case (state_q)
      START: state_d = init ? LOAD : START;
      LOAD: begin
        ld      = 1'b1;
        state_d = CHECK;
      end
      CHECK: state_d = z ? DONE : SHIFT;
      SHIFT: begin
        sft     = 1'b1;
        state_d = CHECK;
      end
      DONE:    state_d = START;
      default: state_d = START;
    endcase
  end

  assign busy  = (state_q != START);
  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

// File: rtl/ones_mask_gen.sv
// Builds a thermometer word with min(count, WIDTH) ones at the LSB end,
// shifting in one bit per SHIFT state.
module ones_mask_gen
  import ones_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = calc_cw(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  ones_mask_gen_if.slave  bus
);

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    count_sat;
  logic             ld;
  logic             sft;
  logic             z;
  logic             busy;
  logic             done;
  state_t           state;

  // Clamping here is what keeps cnt from ever exceeding the word width.
  assign count_sat = (bus.count > WIDTH_C) ? WIDTH_C : bus.count;
  assign z         = (cnt_q == '0);

  control_ones_gen u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .init  (bus.init),
    .z     (z),
    .ld    (ld),
    .sft   (sft),
    .busy  (busy),
    .done  (done),
    .state (state)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      result_q <= '0;
      cnt_q    <= '0;
    end else if (ld) begin
      result_q <= '0;
      cnt_q    <= count_sat;
    end else if (sft) begin
      result_q <= {result_q[WIDTH-2:0], 1'b1};
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.state  = state;

endmodule

// File: tb/tb_ones_mask_gen.sv
// Self-checking bench for ones_mask_gen (WIDTH=8): vector table, random
// operations against an arithmetic model, reset and back-to-back sequences.
module tb_ones_mask_gen;
  import ones_gen_pkg::*;

  localparam int WIDTH = 8;
  localparam int CW    = calc_cw(WIDTH);

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ones_mask_gen_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  ones_mask_gen #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset: registers move on the falling edge, the bench drives
  // and samples on the rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int             cnt_in;
    logic [WIDTH-1:0] exp_result;
    int             exp_lat;
  } vec_t;

  vec_t vecs[$];
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: k = min(count, WIDTH), mask = 2^k - 1, latency 3 + 2k.
  function automatic int model_k(input int c);
    return (c > WIDTH) ? WIDTH : c;
  endfunction

  function automatic logic [WIDTH-1:0] model_mask(input int c);
    longint m;
    m = (longint'(1) << model_k(c)) - 1;
    return m[WIDTH-1:0];
  endfunction

  // Driver: called at a rising edge with the DUT idle. Returns latency in
  // rising edges from the drive edge to the first done sample.
  task automatic run_op(input int c, input bit hold, input bit chg,
                        output int lat, output logic [WIDTH-1:0] res);
    bit got;
    got = 1'b0;
    lat = -1;
    res = '0;
    bus.count = CW'(c);
    bus.init  = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk);
      if (j == 1 && !hold) bus.init = 1'b0;
      if (chg && j == 4) bus.count = CW'($urandom_range(0, 15));
      if (bus.done) begin
        got = 1'b1;
        lat = j;
        res = bus.result;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("busy_at_done", 32'(bus.busy), 32'd1);
      @(posedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("busy_falls", 32'(bus.busy), 32'd0);
      chk("result_hold", 32'(bus.result), 32'(res));
    end
  endtask

  initial begin
    int lat;
    int c;
    int pulses;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] exp;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.init  = 1'b0;
    bus.count = '0;

    // Reset then idle.
    repeat (2) @(posedge clk);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      chk("idle_state", 32'(bus.state), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
    end

    // Vector table.
    vecs.push_back('{3,  8'b0000_0111, 9});
    vecs.push_back('{0,  8'h00, 3});
    vecs.push_back('{8,  8'hFF, 19});
    vecs.push_back('{13, 8'hFF, 19});
    vecs.push_back('{1,  8'h01, 5});
    vecs.push_back('{15, 8'hFF, 19});
    vecs.push_back('{7,  8'h7F, 17});
    foreach (vecs[i]) begin
      run_op(vecs[i].cnt_in, 1'b0, 1'b0, lat, res);
      chk($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_result));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
    end

    // Saturating count with count changed mid-operation.
    run_op(13, 1'b0, 1'b1, lat, res);
    chk("sat_chg_result", 32'(res), 32'hFF);
    chk("sat_chg_latency", lat, 19);
    run_op(2, 1'b0, 1'b1, lat, res);
    chk("chg_result", 32'(res), 32'h03);

    // Reset mid-operation.
    bus.count = CW'(6);
    bus.init  = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk);
      if (j == 1) bus.init = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    chk("midrst_state", 32'(bus.state), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int j = 0; j < 25; j++) begin
      @(posedge clk);
      if (bus.done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    run_op(2, 1'b0, 1'b0, lat, res);
    chk("after_rst_result", 32'(res), 32'h03);

    // Random operations against the model.
    for (int i = 0; i < 20; i++) begin
      c = $urandom_range(0, 15);
      exp_q.push_back(model_mask(c));
      run_op(c, 1'b0, ($urandom_range(0, 1) == 1), lat, res);
      exp = exp_q.pop_front();
      chk($sformatf("rand%0d_result c=%0d", i, c), 32'(res), 32'(exp));
      chk($sformatf("rand%0d_latency c=%0d", i, c), lat, 3 + 2 * model_k(c));
    end

    // Loopback sweep with init held high: popcount must be min(count, 8)
    // and each run restarts after a single START cycle.
    for (int s = 0; s < 16; s++) begin
      run_op(s, 1'b1, 1'b0, lat, res);
      chk($sformatf("loop%0d_popcount", s), $countones(res), model_k(s));
      chk($sformatf("loop%0d_result", s), 32'(res), 32'(model_mask(s)));
      chk($sformatf("loop%0d_latency", s), lat, 3 + 2 * model_k(s));
    end
    bus.init = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
